// File: rtl/updown_counter_ld.sv
// -----------------------------------------------------------------------------
// updown_counter_ld
//
// Purpose:
//   Loadable, enable-gated binary up/down counter with a single clock domain.
//   A synchronous load takes priority over counting, and the count direction
//   can change on every cycle. All arithmetic wraps modulo 2**WIDTH. There is
//   no carry, borrow or saturation output.
//
// Ports:
//   clk    in   1      Clock. All state changes happen on the rising edge.
//   rst_n  in   1      Synchronous active-low reset. Clears the count.
//   D      in   WIDTH  Parallel load value.
//   L      in   1      Load request, active-high. Overrides E and S.
//   E      in   1      Count enable, active-high.
//   S      in   1      Direction: 1 = count up, 0 = count down.
//   O      out  WIDTH  Registered counter value, driven straight from the flop.
// -----------------------------------------------------------------------------
module updown_counter_ld #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] D,
   input  logic             L,
   input  logic             E,
   input  logic             S,
   output logic [WIDTH-1:0] O
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next-state selection. A load replaces the value outright, so no count is
   // applied in the same cycle. Add and subtract wrap naturally at WIDTH bits.
   always_comb begin
      count_d = count_q;
      if (L) begin
         count_d = D;
      end else if (E) begin
         if (S) begin
            count_d = count_q + WIDTH'(1);
         end else begin
            count_d = count_q - WIDTH'(1);
         end
      end
   end

   // Reset is sampled on the clock edge and beats a load or a count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign O = count_q;

endmodule

// File: tb/tb_updown_counter_ld.sv
module tb_updown_counter_ld;

   localparam int WIDTH = 4;
   localparam int MODV  = 1 << WIDTH;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] D;
   logic             L;
   logic             E;
   logic             S;
   logic [WIDTH-1:0] O;

   int n_assert;
   int n_fail;
   int model;        // reference count value, -1 while unknown (before reset)

   updown_counter_ld #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .D     (D),
      .L     (L),
      .E     (E),
      .S     (S),
      .O     (O)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: one clock edge's worth of the counter's rules.
   function automatic int next_model(int cur, logic r, logic l, logic e,
                                     logic s, int d);
      if (!r)      return 0;
      else if (l)  return d;
      else if (cur < 0) return -1;
      else if (e && s)  return (cur + 1) % MODV;
      else if (e)       return (cur + MODV - 1) % MODV;
      else              return cur;
   endfunction

   task automatic check(input string tag, input logic [WIDTH-1:0] exp);
      n_assert++;
      assert (O === exp)
      else begin
         n_fail++;
         $error("FAIL %s: O=%0h expected %0h", tag, O, exp);
      end
   endtask

   // Apply inputs ahead of the next rising edge, advance the model, then sample
   // 1 ns after the edge.
   task automatic drive(input logic r, input logic l, input logic e,
                        input logic s, input logic [WIDTH-1:0] d);
      rst_n = r;
      L     = l;
      E     = e;
      S     = s;
      D     = d;
      @(posedge clk);
      model = next_model(model, r, l, e, s, int'(d));
      #1;
   endtask

   // Directed step: checks against a hand-written constant and keeps the model
   // in step so the random phase starts from a known value.
   task automatic step(input string tag, input logic r, input logic l,
                       input logic e, input logic s, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] exp);
      drive(r, l, e, s, d);
      check(tag, exp);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      model    = -1;
      rst_n = 1'b0; L = 1'b0; E = 1'b0; S = 1'b0; D = '0;

      // Reset beats load and count
      step("reset_beats_load", 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'h0);
      step("count_after_release", 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 4'h1);

      // Load wins over count; load without enable
      step("load_wins_over_count", 1'b1, 1'b1, 1'b1, 1'b1, 4'b0101, 4'b0101);
      step("load_without_enable", 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 4'h9);
      step("load_again", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0101, 4'b0101);

      // Hold with D and S toggling
      step("hold_1", 1'b1, 1'b0, 1'b0, 1'b1, 4'hA, 4'b0101);
      step("hold_2", 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'b0101);
      step("hold_3", 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 4'b0101);

      // Direction turnarounds
      step("up_1", 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'b0110);
      step("down_1", 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0101);
      step("up_2", 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'b0110);
      step("down_2", 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0101);
      step("down_3", 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0100);

      // Wrap-around both ways
      step("load_all_ones", 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
      step("wrap_up", 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
      step("wrap_down", 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'hF);

      // Mid-run reset
      step("load_three", 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd3);
      step("run_up_1", 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd4);
      step("run_up_2", 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5);
      step("midrun_reset", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
      step("resume_after_reset", 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1);

      // Random phase against the reference model
      for (int i = 0; i < 400; i++) begin
         logic r, l, e, s;
         logic [WIDTH-1:0] d;
         r = ($urandom_range(0, 15) != 0);
         l = ($urandom_range(0, 3) == 0);
         e = ($urandom_range(0, 3) != 0);
         s = 1'($urandom_range(0, 1));
         d = WIDTH'($urandom_range(0, MODV - 1));
         drive(r, l, e, s, d);
         check("random", WIDTH'(model));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
